// File: rtl/f_wb_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | f_wb_arbiter_pkg : shared FP register-file definitions (widths, fflags   |
// |                    layout, writeback source encoding).                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package f_wb_arbiter_pkg;

   localparam int FREG_IDX_W = 5;
   localparam int FREG_CNT   = 32;
   localparam int FFLAGS_W   = 5;

   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } fflags_t;

   typedef enum logic {
      WB_FPU = 1'b0,
      WB_LD  = 1'b1
   } wb_src_t;

   function automatic logic [FREG_CNT-1:0] freg_onehot(input logic [FREG_IDX_W-1:0] idx);
      return FREG_CNT'(1) << idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/f_wb_arbiter_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | f_scoreboard : per-register pending-write tracking and RAW/WAW hazard    |
// |                detection for the FP register file.                       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module f_scoreboard
   import f_wb_arbiter_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  issue_valid,
   input  logic [FREG_IDX_W-1:0] issue_rd,
   input  logic [FREG_IDX_W-1:0] issue_rs1,
   input  logic [FREG_IDX_W-1:0] issue_rs2,
   input  logic                  wb_en,
   input  logic [FREG_IDX_W-1:0] wb_rd,
   output logic [FREG_CNT-1:0]   busy,
   output logic                  issue_stall
);

   logic [FREG_CNT-1:0] r_busy;
   logic [FREG_CNT-1:0] w_set;
   logic [FREG_CNT-1:0] w_clr;
   logic                w_stall;

   // No bypass from the write port: a register stays busy through its f_wen cycle.
   assign w_stall = issue_valid & (r_busy[issue_rs1] | r_busy[issue_rs2] | r_busy[issue_rd]);

   assign w_set = (issue_valid & ~w_stall) ? freg_onehot(issue_rd) : '0;
   assign w_clr = wb_en ? freg_onehot(wb_rd) : '0;

   // Set is applied after clear so a same-index collision leaves the bit set.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_busy <= '0;
      end else begin
         r_busy <= (r_busy & ~w_clr) | w_set;
      end
   end

   assign busy        = r_busy;
   assign issue_stall = w_stall;

endmodule
`default_nettype wire

// File: rtl/f_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | f_wb_arbiter : round-robin FPU / FP-load writeback arbiter with a single |
// |                registered FP register-file write port and sticky fflags. |
// |                Optional scoreboard under macro F_WB_SCOREBOARD_EN.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module f_wb_arbiter
   import f_wb_arbiter_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  issue_valid,
   input  logic [FREG_IDX_W-1:0] issue_rd,
   input  logic [FREG_IDX_W-1:0] issue_rs1,
   input  logic [FREG_IDX_W-1:0] issue_rs2,
   output logic                  issue_stall,
   input  logic                  fpu_valid,
   output logic                  fpu_ready,
   input  logic [FREG_IDX_W-1:0] fpu_rd,
   input  logic [31:0]           fpu_data,
   input  logic [FFLAGS_W-1:0]   fpu_flags,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [FREG_IDX_W-1:0] ld_rd,
   input  logic [31:0]           ld_data,
   output logic                  f_wen,
   output logic [FREG_IDX_W-1:0] f_rd,
   output logic [31:0]           f_w_data,
   output logic [FFLAGS_W-1:0]   fflags,
   input  logic                  fflags_clr,
   output logic [FREG_CNT-1:0]   busy
);

   wb_src_t               r_last_grant;
   logic                  r_wen;
   logic [FREG_IDX_W-1:0] r_rd;
   logic [31:0]           r_data;
   fflags_t               r_fflags;

   logic                  w_fpu_xfer;
   logic                  w_ld_xfer;
   fflags_t               w_fflags_base;

   // Grants are mutually exclusive, so at most one transfer per cycle.
   assign w_fpu_xfer = fpu_valid & (~ld_valid  | (r_last_grant == WB_LD));
   assign w_ld_xfer  = ld_valid  & (~fpu_valid | (r_last_grant == WB_FPU));

   assign fpu_ready = w_fpu_xfer;
   assign ld_ready  = w_ld_xfer;

   assign w_fflags_base = fflags_clr ? fflags_t'('0) : r_fflags;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_last_grant <= WB_LD;
         r_wen        <= 1'b0;
         r_rd         <= '0;
         r_data       <= '0;
         r_fflags     <= '0;
      end else begin
         r_wen <= w_fpu_xfer | w_ld_xfer;
         if (w_fpu_xfer) begin
            r_last_grant <= WB_FPU;
            r_rd         <= fpu_rd;
            r_data       <= fpu_data;
            r_fflags     <= w_fflags_base | fflags_t'(fpu_flags);
         end else begin
            r_fflags <= w_fflags_base;
            if (w_ld_xfer) begin
               r_last_grant <= WB_LD;
               r_rd         <= ld_rd;
               r_data       <= ld_data;
            end
         end
      end
   end

   assign f_wen    = r_wen;
   assign f_rd     = r_rd;
   assign f_w_data = r_data;
   assign fflags   = r_fflags;

`ifdef F_WB_SCOREBOARD_EN
   f_scoreboard u_scoreboard (
      .CLK         (CLK),
      .RST         (RST),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .issue_rs1   (issue_rs1),
      .issue_rs2   (issue_rs2),
      .wb_en       (r_wen),
      .wb_rd       (r_rd),
      .busy        (busy),
      .issue_stall (issue_stall)
   );
`else
   logic w_unused_issue;
   assign w_unused_issue = ^{issue_valid, issue_rd, issue_rs1, issue_rs2};
   assign busy           = '0;
   assign issue_stall    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_f_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_f_wb_arbiter : self-checking bench for f_wb_arbiter (either build of  |
// |                   F_WB_SCOREBOARD_EN).                                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_f_wb_arbiter;

`ifdef F_WB_SCOREBOARD_EN
   localparam logic c_sb = 1'b1;
`else
   localparam logic c_sb = 1'b0;
`endif

   logic        CLK;
   logic        RST;
   logic        issue_valid;
   logic [4:0]  issue_rd, issue_rs1, issue_rs2;
   logic        issue_stall;
   logic        fpu_valid, fpu_ready;
   logic [4:0]  fpu_rd;
   logic [31:0] fpu_data;
   logic [4:0]  fpu_flags;
   logic        ld_valid, ld_ready;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic        f_wen;
   logic [4:0]  f_rd;
   logic [31:0] f_w_data;
   logic [4:0]  fflags;
   logic        fflags_clr;
   logic [31:0] busy;

   f_wb_arbiter dut (
      .CLK         (CLK),
      .RST         (RST),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .issue_rs1   (issue_rs1),
      .issue_rs2   (issue_rs2),
      .issue_stall (issue_stall),
      .fpu_valid   (fpu_valid),
      .fpu_ready   (fpu_ready),
      .fpu_rd      (fpu_rd),
      .fpu_data    (fpu_data),
      .fpu_flags   (fpu_flags),
      .ld_valid    (ld_valid),
      .ld_ready    (ld_ready),
      .ld_rd       (ld_rd),
      .ld_data     (ld_data),
      .f_wen       (f_wen),
      .f_rd        (f_rd),
      .f_w_data    (f_w_data),
      .fflags      (fflags),
      .fflags_clr  (fflags_clr),
      .busy        (busy)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int n_pass = 0;
   int n_chk  = 0;

   // Reference model state
   logic        m_known = 1'b0;
   logic        m_last  = 1'b1;   // 0 = FPU granted last, 1 = LD
   logic [4:0]  m_ff    = '0;
   logic [31:0] m_busy  = '0;
   logic        m_wen   = 1'b0;
   logic [4:0]  m_rd    = '0;
   logic [36:0] q[$];

   typedef struct {
      logic        fv;
      logic [4:0]  frd;
      logic [31:0] fdata;
      logic        lv;
      logic [4:0]  lrd;
      logic [31:0] ldata;
      logic        exp_fr;
      logic        exp_lr;
   } vec_t;

   vec_t vt[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else
         n_pass++;
   endtask

   task automatic idle();
      fpu_valid = 0; ld_valid = 0; issue_valid = 0; fflags_clr = 0; fpu_flags = '0;
   endtask

   task automatic tick();
      logic gf, gl, st;
      logic [36:0] e;
      #1;
      gf = fpu_valid && (!ld_valid || m_last == 1'b1);
      gl = ld_valid && (!fpu_valid || m_last == 1'b0);
`ifdef F_WB_SCOREBOARD_EN
      st = issue_valid && (m_busy[issue_rs1] || m_busy[issue_rs2] || m_busy[issue_rd]);
`else
      st = 1'b0;
`endif
      if (m_known) begin
         chk("fpu_ready", 32'(fpu_ready), 32'(gf));
         chk("ld_ready", 32'(ld_ready), 32'(gl));
         chk("issue_stall", 32'(issue_stall), 32'(st));
         chk("busy", busy, m_busy);
         chk("fflags", 32'(fflags), 32'(m_ff));
      end
      if (RST) begin
         q.delete();
         m_last = 1'b1; m_ff = '0; m_busy = '0; m_known = 1'b1;
      end else begin
`ifdef F_WB_SCOREBOARD_EN
         if (m_wen) m_busy[m_rd] = 1'b0;
         if (issue_valid && !st) m_busy[issue_rd] = 1'b1;
`endif
         if (fflags_clr) m_ff = '0;
         if (gf) begin
            q.push_back({fpu_rd, fpu_data}); m_last = 1'b0; m_ff = m_ff | fpu_flags;
         end else if (gl) begin
            q.push_back({ld_rd, ld_data}); m_last = 1'b1;
         end
      end
      @(posedge CLK); #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("f_wen", 32'(f_wen), 32'd1);
         chk("f_rd", 32'(f_rd), 32'(e[36:32]));
         chk("f_w_data", f_w_data, e[31:0]);
         m_wen = 1'b1; m_rd = e[36:32];
      end else begin
         chk("f_wen_idle", 32'(f_wen), 32'd0);
         m_wen = 1'b0;
      end
   endtask

   initial begin
      vt[0] = '{1, 3, 32'hA000_0003, 1, 4, 32'hB000_0004, 1, 0};
      vt[1] = '{1, 3, 32'hA100_0003, 1, 4, 32'hB100_0004, 0, 1};
      vt[2] = '{1, 3, 32'hA200_0003, 1, 4, 32'hB200_0004, 1, 0};
      vt[3] = '{1, 3, 32'hA300_0003, 1, 4, 32'hB300_0004, 0, 1};
      vt[4] = '{1, 5, 32'h1234_5678, 0, 6, 32'h0,         1, 0};
      vt[5] = '{0, 5, 32'h0,         1, 6, 32'h8765_4321, 0, 1};
      vt[6] = '{0, 1, 32'h0,         0, 2, 32'h0,         0, 0};
      vt[7] = '{0, 1, 32'h0,         1, 0, 32'hDEAD_BEEF, 0, 1};
      vt[8] = '{1, 0, 32'hCAFE_F00D, 0, 2, 32'h0,         1, 0};
      vt[9] = '{1, 10, 32'h5555_AAAA, 1, 11, 32'hAAAA_5555, 0, 1};

      RST = 1; idle();
      issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
      fpu_rd = 0; fpu_data = 0; ld_rd = 0; ld_data = 0;

      // Reset with both channels requesting
      fpu_valid = 1; ld_valid = 1;
      tick(); tick();
      RST = 0;
      chk("rst_f_wen", 32'(f_wen), 32'd0);
      chk("rst_fflags", 32'(fflags), 32'd0);
      chk("rst_busy", busy, 32'd0);

      // Contention / single-channel table; first row is the first contended grant
      for (int i = 0; i < 10; i++) begin
         fpu_valid = vt[i].fv; fpu_rd = vt[i].frd; fpu_data = vt[i].fdata;
         ld_valid = vt[i].lv; ld_rd = vt[i].lrd; ld_data = vt[i].ldata;
         #1;
         chk($sformatf("tbl%0d_fpu_ready", i), 32'(fpu_ready), 32'(vt[i].exp_fr));
         chk($sformatf("tbl%0d_ld_ready", i), 32'(ld_ready), 32'(vt[i].exp_lr));
         tick();
      end
      idle(); tick();

      // Sticky flags
      fflags_clr = 1; tick(); fflags_clr = 0;
      fpu_valid = 1; fpu_rd = 1; fpu_data = 32'h1; fpu_flags = 5'b00001; tick();
      fpu_flags = 5'b10000; fpu_data = 32'h2; tick();
      idle(); tick();
      chk("fflags_accum", 32'(fflags), 32'h11);
      fflags_clr = 1; fpu_valid = 1; fpu_flags = 5'b00100; fpu_data = 32'h3; tick();
      idle(); tick();
      chk("fflags_clr_or", 32'(fflags), 32'h04);
      ld_valid = 1; ld_rd = 2; ld_data = 32'h77; tick();
      idle(); tick();
      chk("fflags_ld_keep", 32'(fflags), 32'h04);

      // RAW hazard on f7
      issue_valid = 1; issue_rd = 7; issue_rs1 = 0; issue_rs2 = 0; tick();
      issue_rd = 8; issue_rs1 = 7; issue_rs2 = 1; #1;
      chk("stall_raw", 32'(issue_stall), 32'(c_sb));
      tick(); tick();
      fpu_valid = 1; fpu_rd = 7; fpu_data = 32'h0000_0777; tick();
      fpu_valid = 0; #1;
      chk("stall_during_wen", 32'(issue_stall), 32'(c_sb));
      tick(); #1;
      chk("stall_released", 32'(issue_stall), 32'd0);
      tick();
      issue_valid = 0; tick();
      chk("busy8_set", 32'(busy[8]), 32'(c_sb));

      // Set/clear race on f9
      fpu_valid = 1; fpu_rd = 9; fpu_data = 32'h9999; tick();
      fpu_valid = 0; issue_valid = 1; issue_rd = 9; issue_rs1 = 1; issue_rs2 = 2;
      tick();
      issue_valid = 0; tick();
      chk("busy9_race", 32'(busy[9]), 32'(c_sb));

      // Reset with a transfer in flight
      fpu_valid = 1; fpu_rd = 12; fpu_data = 32'hBAD0_BAD0; fpu_flags = 5'b01010;
      RST = 1; tick();
      RST = 0; idle(); #1;
      chk("midrst_fflags", 32'(fflags), 32'd0);
      chk("midrst_busy", busy, 32'd0);
      fpu_valid = 1; ld_valid = 1; fpu_rd = 13; ld_rd = 14;
      fpu_data = 32'h1313; ld_data = 32'h1414; #1;
      chk("midrst_fpu_first", 32'(fpu_ready), 32'd1);
      tick();
      idle(); tick(); tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
